ccff_bitstream_loader: RTL and testbench

//  Streams a configuration bitstream from a word-wide source into the serial ccff chain (drives ccff_head of the first tile).

---
 rtl/ccff_loader_pkg.sv | 24 ++
 rtl/ccff_word_serializer.sv | 66 ++++++
 rtl/ccff_bitstream_loader.sv | 146 ++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and elaboration-time helpers for the ccff bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Number of source words needed to cover the whole chain.
  function automatic int unsigned words_for(input int unsigned chain_len,
                                            input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Ceiling log2, usable in parameter defaults.
  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Single-word PISO for the ccff stream. A word arriving while the holder is empty
// is bypassed straight to bit_out_c, so back-to-back words stream without a bubble.
module ccff_word_serializer
  import ccff_loader_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LAST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid_i,
  input  logic              load_ready_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic              truncate_i,
  output logic              bit_valid_c,
  output logic              bit_out_c,
  output logic              last_bit_next_c
);

  localparam int unsigned CW = clog2_u(WORD_W + 1);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              load_c;
  logic [CW-1:0]     load_bits_c;

  assign load_c      = load_valid_i & load_ready_i;
  assign load_bits_c = truncate_i ? CW'(LAST_W) : CW'(WORD_W);

  // Select the outgoing bit and compute the next holder contents.
  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    bit_valid_c = 1'b0;
    bit_out_c   = shreg_q[0];
    if (cnt_q != '0) begin
      bit_valid_c = 1'b1;
      shreg_d     = shreg_q >> 1;
      cnt_d       = cnt_q - CW'(1);
      if (load_c) begin
        shreg_d = load_data_i;
        cnt_d   = load_bits_c;
      end
    end else if (load_c) begin
      bit_valid_c = 1'b1;
      bit_out_c   = load_data_i[0];
      shreg_d     = load_data_i >> 1;
      cnt_d       = load_bits_c - CW'(1);
    end
  end

  // Next cycle the holder is empty or releases its last bit, so it can take a word.
  assign last_bit_next_c = (cnt_d <= CW'(1));

  // Holder register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams a word-wide configuration bitstream into the serial ccff chain, gating the
// chain clock on source stalls, isolating the tiles while programming, and counting
// the ones that fall out of the chain tail as a readback signature.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 1024,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CNT_W     = clog2_u(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              isol_n,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  tail_ones
);

  localparam int unsigned WORDS  = words_for(CHAIN_LEN, WORD_W);
  localparam int unsigned LAST_W = CHAIN_LEN - (WORDS - 1) * WORD_W;
  localparam int unsigned WCNT_W = clog2_u(WORDS + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WCNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   tail_q, tail_d;
  logic               head_q, head_d;
  logic               clk_en_q, clk_en_d;
  logic               ready_q, ready_d;
  logic               isol_q, isol_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_c;
  logic               truncate_c;
  logic               ser_bit_valid_c;
  logic               ser_bit_c;
  logic               ser_last_next_c;

  assign accept_c   = cfg_valid & ready_q;
  assign truncate_c = (word_cnt_q == WCNT_W'(WORDS - 1));

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .LAST_W (LAST_W)
  ) u_ser (
    .clk             (prog_clk),
    .rst_n           (prog_reset_n),
    .load_valid_i    (cfg_valid),
    .load_ready_i    (ready_q),
    .load_data_i     (cfg_data),
    .truncate_i      (truncate_c),
    .bit_valid_c     (ser_bit_valid_c),
    .bit_out_c       (ser_bit_c),
    .last_bit_next_c (ser_last_next_c)
  );

  // Load sequencing, counters and next output values.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    tail_d     = tail_q;
    head_d     = head_q;
    clk_en_d   = 1'b0;
    ready_d    = 1'b0;
    isol_d     = isol_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          tail_d     = '0;
          isol_d     = 1'b0;
          busy_d     = 1'b1;
          ready_d    = 1'b1;
        end
      end
      SHIFT: begin
        if (ser_bit_valid_c) begin
          head_d    = ser_bit_c;
          clk_en_d  = 1'b1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (accept_c) word_cnt_d = word_cnt_q + WCNT_W'(1);
        if (clk_en_q && ccff_tail && (tail_q != CNT_W'(CHAIN_LEN))) tail_d = tail_q + CNT_W'(1);
        ready_d = ser_last_next_c && (word_cnt_d != WCNT_W'(WORDS));
        if (bit_cnt_q == CNT_W'(CHAIN_LEN)) begin
          state_d = DONE;
          ready_d = 1'b0;
          isol_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      tail_q     <= '0;
      head_q     <= 1'b0;
      clk_en_q   <= 1'b0;
      ready_q    <= 1'b0;
      isol_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      tail_q     <= tail_d;
      head_q     <= head_d;
      clk_en_q   <= clk_en_d;
      ready_q    <= ready_d;
      isol_q     <= isol_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign cfg_ready   = ready_q;
  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;
  assign isol_n      = isol_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign tail_ones   = tail_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: a 70-flop and a 64-flop chain model, a head-bit
// scoreboard fed on word acceptance, and load/stall/restart/reset scenarios.
module tb_ccff_bitstream_loader;

  localparam int N1 = 70;
  localparam int N2 = 64;
  localparam int W  = 32;
  localparam int WORDS1 = 3;

  logic          prog_clk = 1'b0;
  logic          prog_reset_n;
  logic          start, cfg_valid, cfg_ready, ccff_head, ccff_clk_en, ccff_tail;
  logic          isol_n, busy, done;
  logic [W-1:0]  cfg_data;
  logic [6:0]    tail_ones;
  logic          start2, valid2, ready2, head2, en2, tail2, isol2, busy2, done2;
  logic [W-1:0]  data2;
  logic [6:0]    tail_ones2;

  logic [N1-1:0] chain = '0;
  logic [N2-1:0] chain2 = '0;
  logic          pre_req;
  logic [N1-1:0] pre_val;
  int            cyc = 0;

  int n_chk = 0;
  int n_pass = 0;

  // Monitor state for the 70-bit loader.
  bit exp_q[$];
  int en_cnt, gap_cnt, done_cnt, acc_cnt, lat, t0, exp_tail;
  bit iso_bad, rdy_bad;

  ccff_bitstream_loader #(.CHAIN_LEN(N1), .WORD_W(W)) dut (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_clk_en(ccff_clk_en), .ccff_tail(ccff_tail),
    .isol_n(isol_n), .busy(busy), .done(done), .tail_ones(tail_ones)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(N2), .WORD_W(W)) dut2 (
    .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .start(start2),
    .cfg_data(data2), .cfg_valid(valid2), .cfg_ready(ready2),
    .ccff_head(head2), .ccff_clk_en(en2), .ccff_tail(tail2),
    .isol_n(isol2), .busy(busy2), .done(done2), .tail_ones(tail_ones2)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) cyc <= cyc + 1;

  // Fabric chain models: head enters the top flop, tail is flop 0.
  always @(posedge prog_clk) begin
    if (pre_req) chain <= pre_val;
    else if (ccff_clk_en) chain <= {ccff_head, chain[N1-1:1]};
    if (en2) chain2 <= {head2, chain2[N2-1:1]};
  end
  assign ccff_tail = chain[0];
  assign tail2     = chain2[0];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Scoreboard and per-load statistics, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge prog_clk);
      if (!prog_reset_n) begin
        exp_q.delete();
        en_cnt = 0; gap_cnt = 0; done_cnt = 0; acc_cnt = 0;
        iso_bad = 0; rdy_bad = 0; lat = -1;
      end else begin
        if (start && !busy && !done) begin
          exp_q.delete();
          en_cnt = 0; gap_cnt = 0; done_cnt = 0; acc_cnt = 0;
          iso_bad = 0; rdy_bad = 0; lat = -1;
          t0 = cyc;
          exp_tail = $countones(chain);
        end
        if (cfg_ready && acc_cnt == WORDS1) rdy_bad = 1;
        if (cfg_valid && cfg_ready) begin
          for (int b = 0; b < W; b++)
            if (acc_cnt * W + b < N1) exp_q.push_back(cfg_data[b]);
          acc_cnt++;
        end
        if (ccff_clk_en) begin
          if (exp_q.size() == 0) chk("head_extra_shift", 1, 0);
          else chk("head_bit", int'(ccff_head), int'(exp_q.pop_front()));
          en_cnt++;
        end else if (busy && en_cnt > 0 && en_cnt < N1) begin
          gap_cnt++;
        end
        if (busy && isol_n) iso_bad = 1;
        if (done) begin
          done_cnt++;
          if (lat < 0) lat = cyc - t0;
        end
      end
    end
  end

  // One load of the 70-bit chain; stall withholds word1 once the loader first asks for it,
  // poke pulses start mid-shift and in the done cycle, abort_at resets after that many shifts.
  task automatic load1(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2,
                       input int stall, input bit poke, input int abort_at);
    logic [W-1:0] wd [3];
    int  wi = 0;
    int  st = 0;
    int  guard = 0;
    bit  stalled = 0;
    bit  acc;
    wd = '{w0, w1, w2};
    @(posedge prog_clk); #1; start = 1'b1;
    @(posedge prog_clk); #1; start = 1'b0;
    while (!done && guard < 400) begin
      if (abort_at > 0 && en_cnt >= abort_at) begin
        #2 prog_reset_n = 1'b0;
        #1;
        chk("rst_ready", int'(cfg_ready), 0);
        chk("rst_head", int'(ccff_head), 0);
        chk("rst_clk_en", int'(ccff_clk_en), 0);
        chk("rst_isol_n", int'(isol_n), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tail_ones", int'(tail_ones), 0);
        cfg_valid = 1'b0;
        repeat (2) @(posedge prog_clk);
        #1 prog_reset_n = 1'b1;
        return;
      end
      if (wi == 1 && cfg_ready && !stalled && stall > 0) begin
        st = stall + 1;
        stalled = 1;
      end
      if (poke && guard == 20) start = 1'b1;
      cfg_valid = (wi < WORDS1) && (st == 0);
      cfg_data  = (wi < WORDS1) ? wd[wi] : $urandom;
      if (st > 0) st--;
      acc = cfg_valid && cfg_ready;
      @(posedge prog_clk); #1; start = 1'b0;
      if (acc) wi++;
      guard++;
    end
    cfg_valid = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
    chk("done_isol_n", int'(isol_n), 1);
    chk("done_busy", int'(busy), 0);
    chk("done_tail_ones", int'(tail_ones), exp_tail);
    if (poke) start = 1'b1;
    @(posedge prog_clk); #1; start = 1'b0;
    repeat (5) @(posedge prog_clk);
    @(negedge prog_clk);
    chk("clk_en_cycles", en_cnt, N1);
    chk("stall_gap", gap_cnt, stall);
    chk("latency", lat, N1 + 2 + stall);
    chk("done_pulses", done_cnt, 1);
    chk("words_taken", acc_cnt, WORDS1);
    chk("sb_empty", exp_q.size(), 0);
    chk("isol_low_while_busy", int'(iso_bad), 0);
    chk("ready_after_last", int'(rdy_bad), 0);
    chk("idle_busy", int'(busy), 0);
    chk("chain_w0", int'(chain[31:0]), int'(wd[0]));
    chk("chain_w1", int'(chain[63:32]), int'(wd[1]));
    chk("chain_w2", int'(chain[69:64]), int'(wd[2][5:0]));
    chk("tail_held", int'(tail_ones), exp_tail);
  endtask

  // One load of the 64-bit chain (exact multiple of the word width).
  task automatic load2(input logic [W-1:0] v0, input logic [W-1:0] v1, input int exp_t);
    logic [W-1:0] vd [2];
    int wi = 0;
    int g = 0;
    int en = 0;
    int t = 1;
    bit rb = 0;
    bit acc;
    vd = '{v0, v1};
    @(posedge prog_clk); #1; start2 = 1'b1;
    @(posedge prog_clk); #1; start2 = 1'b0;
    while (!done2 && g < 300) begin
      valid2 = (wi < 2);
      data2  = (wi < 2) ? vd[wi] : 32'h0;
      @(negedge prog_clk);
      if (en2) en++;
      if (ready2 && wi == 2) rb = 1;
      acc = valid2 && ready2;
      @(posedge prog_clk); #1;
      if (acc) wi++;
      g++;
      t++;
    end
    valid2 = 1'b0;
    if (!done2) chk("d2_done_timeout", 0, 1);
    chk("d2_latency", t, N2 + 2);
    chk("d2_clk_en_cycles", en, N2);
    chk("d2_words", wi, 2);
    chk("d2_ready_after_last", int'(rb), 0);
    chk("d2_isol_n", int'(isol2), 1);
    chk("d2_tail_ones", int'(tail_ones2), exp_t);
    chk("d2_chain_w0", int'(chain2[31:0]), int'(v0));
    chk("d2_chain_w1", int'(chain2[63:32]), int'(v1));
  endtask

  logic [W-1:0] a0, a1, a2, b0, b1, b2, c0, c1;
  int pc_a;

  initial begin
    prog_reset_n = 1'b0;
    start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    start2 = 1'b0; valid2 = 1'b0; data2 = '0;
    pre_req = 1'b0; pre_val = '0;
    a0 = 32'hA5C3_0F96; a1 = 32'h1234_ABCD; a2 = 32'hFFFF_FFC5;
    b0 = 32'h0F0F_3C3C; b1 = 32'hDEAD_BEEF; b2 = 32'h8000_002A;
    c0 = 32'hCAFE_F00D; c1 = 32'h0000_0001;
    pc_a = $countones({a2[5:0], a1, a0});
    repeat (3) @(posedge prog_clk);
    @(negedge prog_clk);
    chk("reset_ready", int'(cfg_ready), 0);
    chk("reset_head", int'(ccff_head), 0);
    chk("reset_clk_en", int'(ccff_clk_en), 0);
    chk("reset_isol_n", int'(isol_n), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_tail_ones", int'(tail_ones), 0);
    chk("reset_isol2", int'(isol2), 0);
    @(posedge prog_clk); #1 prog_reset_n = 1'b1;
    repeat (2) @(posedge prog_clk);
    #1 chk("isol_n_before_first_load", int'(isol_n), 0);

    // Continuous stream, then the same stream with a 5-cycle source stall.
    load1(a0, a1, a2, 0, 1'b0, 0);
    load1(a0, a1, a2, 5, 1'b0, 0);

    // Readback: 17 ones preloaded, then the previous bitstream.
    @(posedge prog_clk); #1; pre_val = '0; pre_val[16:0] = 17'h1FFFF; pre_req = 1'b1;
    @(posedge prog_clk); #1; pre_req = 1'b0;
    load1(a0, a1, a2, 0, 1'b0, 0);
    chk("tail_ones_preload17", int'(tail_ones), 17);
    load1(a0, a1, a2, 0, 1'b0, 0);
    chk("tail_ones_popcount", int'(tail_ones), pc_a);

    // Start pulses while shifting and in the done cycle are ignored.
    load1(b0, b1, b2, 0, 1'b1, 0);

    // Reset after 40 shifts, then a clean reload.
    load1(a0, a1, a2, 0, 1'b0, 40);
    #1 chk("post_abort_isol_n", int'(isol_n), 0);
    load1(b0, b1, b2, 0, 1'b0, 0);

    // Exact-multiple chain: two words, 64 shifts.
    load2(c0, c1, 0);
    load2(c0, c1, $countones({c1, c0}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
